// File: rtl/xadc_drp_scanner.sv
// XADC DRP read sequencer: scans NUM_CH status addresses per trigger, averages over 2^AVG_LOG2 scans.
// States: STARTUP power-up wait | IDLE armed | ISSUE den pulse | WAIT_RDY capture/timeout | NEXT advance | ENDSCAN emit
module xadc_drp_scanner #(
  parameter int                  NUM_CH         = 2,
  parameter logic [7*NUM_CH-1:0] ADDR_LIST      = {7'h1F, 7'h00},
  parameter int                  STARTUP_CYCLES = 1_000_000,
  parameter int                  TIMEOUT_CYCLES = 255,
  parameter int                  AVG_LOG2       = 0,
  localparam int                 CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig_mode,
  input  logic                  start,
  input  logic                  eoc,
  output logic [6:0]            drp_daddr,
  output logic                  drp_den,
  output logic                  drp_dwe,
  output logic [15:0]           drp_di,
  input  logic                  drp_drdy,
  input  logic [15:0]           drp_do,
  output logic [15:0]           sample_data,
  output logic [CH_W-1:0]       sample_ch,
  output logic                  sample_valid,
  output logic [16*NUM_CH-1:0]  all_data,
  output logic                  scan_done,
  output logic                  timeout_err,
  output logic                  busy
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SU_W  = $clog2(STARTUP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic [SU_W-1:0] SU_LAST   = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_IDLE, ST_ISSUE, ST_WAIT_RDY, ST_NEXT, ST_ENDSCAN
  } state_t;

  state_t            state;
  logic [SU_W-1:0]   su_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SC_W-1:0]   scan_cnt;
  logic [CH_W-1:0]   ch_idx;
  logic              emitting;
  logic              emit_more;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [6:0]        addr_tab [NUM_CH];
  logic [CH_W-1:0]   emit_ch;
  logic              do_emit;
  logic              last_ch;
  logic              scan_wrap;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) addr_tab[i] = ADDR_LIST[7*i +: 7];
  end

  assign last_ch   = (ch_idx == LAST_CH);
  assign scan_wrap = (scan_cnt == SCAN_LAST);
  // Channel 0 is emitted on entry to ENDSCAN so the first result leaves with no extra cycle.
  assign emit_ch   = (state == ST_ENDSCAN) ? ch_idx : '0;
  assign do_emit   = ((state == ST_NEXT) && last_ch && scan_wrap) ||
                     ((state == ST_ENDSCAN) && emitting && emit_more);

  assign drp_dwe = 1'b0;
  assign drp_di  = '0;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_STARTUP;
      su_cnt       <= '0;
      to_cnt       <= '0;
      scan_cnt     <= '0;
      ch_idx       <= '0;
      emitting     <= 1'b0;
      emit_more    <= 1'b0;
      drp_daddr    <= '0;
      drp_den      <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      all_data     <= '0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      drp_den      <= 1'b0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (su_cnt == SU_LAST) state <= ST_IDLE;
          else su_cnt <= su_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (trig_mode ? start : eoc) begin
            ch_idx    <= '0;
            drp_daddr <= addr_tab[0];
            drp_den   <= 1'b1;
            to_cnt    <= TO_LOAD;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
          state <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (drp_drdy) begin
            acc[ch_idx] <= acc[ch_idx] + ACC_W'(drp_do);
            state       <= ST_NEXT;
          end else if (to_cnt == '0) begin
            timeout_err <= 1'b1;
            scan_cnt    <= '0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        ST_NEXT: begin
          if (last_ch) begin
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
            emitting  <= scan_wrap;
            emit_more <= scan_wrap && (NUM_CH > 1);
            ch_idx    <= (NUM_CH > 1) ? CH_W'(1) : '0;
            state     <= ST_ENDSCAN;
          end else begin
            ch_idx    <= ch_idx + 1'b1;
            drp_daddr <= addr_tab[ch_idx + 1'b1];
            drp_den   <= 1'b1;
            to_cnt    <= TO_LOAD;
            state     <= ST_ISSUE;
          end
        end
        ST_ENDSCAN: begin
          if (!emitting) begin
            state <= ST_IDLE;
          end else if (emit_more) begin
            if (last_ch) emit_more <= 1'b0;
            else ch_idx <= ch_idx + 1'b1;
          end else begin
            emitting  <= 1'b0;
            scan_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_emit) begin
        sample_valid                   <= 1'b1;
        sample_ch                      <= emit_ch;
        sample_data                    <= 16'(acc[emit_ch] >> AVG_LOG2);
        all_data[16*int'(emit_ch) +: 16] <= 16'(acc[emit_ch] >> AVG_LOG2);
        acc[emit_ch]                   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Bench for xadc_drp_scanner: a dual-channel instance (no averaging) and a single-channel 4-scan averaging instance.
module tb_xadc_drp_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instance A: two channels, no averaging
  logic        a_rst, a_mode, a_start, a_eoc, a_den, a_dwe, a_drdy, a_valid, a_done, a_terr, a_busy;
  logic [6:0]  a_daddr;
  logic [15:0] a_di, a_do, a_sdata;
  logic [0:0]  a_sch;
  logic [31:0] a_all;

  xadc_drp_scanner #(.NUM_CH(2), .ADDR_LIST({7'h1F, 7'h00}), .STARTUP_CYCLES(100),
                     .TIMEOUT_CYCLES(255), .AVG_LOG2(0)) dut_a (
    .clk(clk), .reset(a_rst), .trig_mode(a_mode), .start(a_start), .eoc(a_eoc),
    .drp_daddr(a_daddr), .drp_den(a_den), .drp_dwe(a_dwe), .drp_di(a_di),
    .drp_drdy(a_drdy), .drp_do(a_do), .sample_data(a_sdata), .sample_ch(a_sch),
    .sample_valid(a_valid), .all_data(a_all), .scan_done(a_done),
    .timeout_err(a_terr), .busy(a_busy));

  // Instance B: one channel, average of four scans
  logic        b_rst, b_mode, b_start, b_eoc, b_den, b_dwe, b_drdy, b_valid, b_done, b_terr, b_busy;
  logic [6:0]  b_daddr;
  logic [15:0] b_di, b_do, b_sdata;
  logic [0:0]  b_sch;
  logic [15:0] b_all;

  xadc_drp_scanner #(.NUM_CH(1), .ADDR_LIST(7'h05), .STARTUP_CYCLES(20),
                     .TIMEOUT_CYCLES(255), .AVG_LOG2(2)) dut_b (
    .clk(clk), .reset(b_rst), .trig_mode(b_mode), .start(b_start), .eoc(b_eoc),
    .drp_daddr(b_daddr), .drp_den(b_den), .drp_dwe(b_dwe), .drp_di(b_di),
    .drp_drdy(b_drdy), .drp_do(b_do), .sample_data(b_sdata), .sample_ch(b_sch),
    .sample_valid(b_valid), .all_data(b_all), .scan_done(b_done),
    .timeout_err(b_terr), .busy(b_busy));

  // DRP responders: drdy arrives dly cycles after den
  logic        a_resp = 1'b1;
  int          a_dly = 3;
  int          a_cnt = 0;
  logic [6:0]  a_paddr = '0;
  logic [15:0] a_d0 = 16'h9C40, a_d1 = 16'h7FF0;
  int          b_dly = 2;
  int          b_cnt = 0;
  logic [15:0] b_val = '0;

  initial begin
    a_drdy = 1'b0; a_do = '0; b_drdy = 1'b0; b_do = '0;
  end

  always @(negedge clk) begin
    a_drdy = 1'b0;
    if (a_cnt > 0) begin
      a_cnt = a_cnt - 1;
      if (a_cnt == 0) begin
        a_drdy = 1'b1;
        a_do   = (a_paddr == 7'h1F) ? a_d1 : a_d0;
      end
    end
    if (a_den && a_resp) begin
      a_cnt   = a_dly;
      a_paddr = a_daddr;
    end
  end

  always @(negedge clk) begin
    b_drdy = 1'b0;
    if (b_cnt > 0) begin
      b_cnt = b_cnt - 1;
      if (b_cnt == 0) begin
        b_drdy = 1'b1;
        b_do   = b_val;
      end
    end
    if (b_den) b_cnt = b_dly;
  end

  // Scoreboards: {ch[3:0], data[15:0]}
  logic [19:0] a_exp[$];
  logic [19:0] b_exp[$];
  logic [19:0] a_e, b_e;
  int a_vcnt = 0, a_dcnt = 0, a_dencnt = 0, b_vcnt = 0, b_dcnt = 0;

  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_den) a_dencnt++;
      if (a_done) a_dcnt++;
      if (a_valid) begin
        a_vcnt++;
        if (a_exp.size() == 0) check("a_spurious_valid", 32'(a_valid), 0);
        else begin
          a_e = a_exp.pop_front();
          check("a_ch", 32'(a_sch), 32'(a_e[19:16]));
          check("a_data", 32'(a_sdata), 32'(a_e[15:0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_done) b_dcnt++;
      if (b_valid) begin
        b_vcnt++;
        if (b_exp.size() == 0) check("b_spurious_valid", 32'(b_valid), 0);
        else begin
          b_e = b_exp.pop_front();
          check("b_ch", 32'(b_sch), 32'(b_e[19:16]));
          check("b_data", 32'(b_sdata), 32'(b_e[15:0]));
        end
      end
    end
  end

  int b_vals[8] = '{100, 101, 102, 105, 4, 4, 4, 8};

  initial begin
    int k, kv, dc;
    a_rst = 1'b1; a_mode = 1'b0; a_start = 1'b0; a_eoc = 1'b1;
    b_rst = 1'b1; b_mode = 1'b0; b_start = 1'b0; b_eoc = 1'b0;
    step(3);

    check("rst_daddr", 32'(a_daddr), 0);
    check("rst_den", 32'(a_den), 0);
    check("rst_dwe", 32'(a_dwe), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_all", a_all, 0);
    check("rst_terr", 32'(a_terr), 0);
    check("rst_busy", 32'(a_busy), 1);

    // Averaging over four scans on instance B
    b_rst = 1'b0;
    k = 0;
    while (b_busy && k < 100) begin step(1); k++; end
    check("b_startup_idle", 32'(b_busy), 0);
    for (int s = 0; s < 8; s++) begin
      b_val = 16'(b_vals[s]);
      if (s == 3) b_exp.push_back({4'd0, 16'd102});
      if (s == 7) b_exp.push_back({4'd0, 16'd5});
      b_eoc = 1'b1; step(1); b_eoc = 1'b0;
      check("b_busy_on_trigger", 32'(b_busy), 1);
      k = 0;
      while (b_busy && k < 50) begin step(1); k++; end
      if (s == 2) check("b_no_strobe_scans_1to3", b_vcnt, 0);
      if (s == 3) check("b_strobe_scan4", b_vcnt, 1);
    end
    step(2);
    check("b_valid_count", b_vcnt, 2);
    check("b_done_count", b_dcnt, 2);
    check("b_all_data", 32'(b_all), 5);

    // Startup with eoc held high, then dual scan
    a_exp.push_back({4'd0, 16'h9C40});
    a_exp.push_back({4'd1, 16'h7FF0});
    a_rst = 1'b0;
    k = 0;
    while (!a_den && k < 300) begin step(1); k++; end
    check("a_startup_den_cycle", k + 1, 102);
    check("a_startup_daddr", 32'(a_daddr), 32'h00);
    a_eoc = 1'b0;
    while (!a_valid && k < 400) begin step(1); k++; end
    check("a_dual_latency", k + 1 - 101, 2 * (3 + 2) + 1);
    kv = k;
    while (!a_done && k < kv + 20) begin step(1); k++; end
    check("a_done_after_last", k - kv, 2);
    check("a_all_dual", a_all, 32'h7FF0_9C40);
    check("a_busy_idle", 32'(a_busy), 0);
    check("a_den_count_dual", a_dencnt, 2);

    // Timeout: responder silent
    a_resp = 1'b0;
    a_eoc = 1'b1; step(1); a_eoc = 1'b0;
    check("a_to_den", 32'(a_den), 1);
    k = 0;
    while (!a_terr && k < 400) begin step(1); k++; end
    check("a_timeout_cycles", k, 255);
    check("a_timeout_idle", 32'(a_busy), 0);
    step(3);
    check("a_timeout_no_strobe", a_vcnt, 2);

    // Recovery after timeout
    a_resp = 1'b1; a_dly = 5; a_d0 = 16'h1234; a_d1 = 16'hABCD;
    a_exp.push_back({4'd0, 16'h1234});
    a_exp.push_back({4'd1, 16'hABCD});
    a_eoc = 1'b1; step(1); a_eoc = 1'b0;
    k = 0;
    while (!a_done && k < 100) begin step(1); k++; end
    check("a_recover_done", 32'(a_done), 1);
    check("a_terr_sticky", 32'(a_terr), 1);
    check("a_all_recover", a_all, 32'hABCD_1234);

    // Software trigger mode
    a_mode = 1'b1;
    step(1);
    dc = a_dencnt;
    repeat (20) begin a_eoc = ~a_eoc; step(1); end
    a_eoc = 1'b0;
    step(2);
    check("a_mode1_eoc_ignored", a_dencnt, dc);
    a_dly = 3; a_d0 = 16'h0F0F; a_d1 = 16'hF0F0;
    a_exp.push_back({4'd0, 16'h0F0F});
    a_exp.push_back({4'd1, 16'hF0F0});
    a_start = 1'b1; step(1); a_start = 1'b0;
    check("a_start_den", 32'(a_den), 1);
    step(3);
    a_start = 1'b1; step(1); a_start = 1'b0;
    k = 0;
    while (!a_done && k < 100) begin step(1); k++; end
    step(20);
    check("a_start_den_total", a_dencnt, dc + 2);
    check("a_mode1_all", a_all, 32'hF0F0_0F0F);

    // Reset in WAIT_RDY; drdy lands one cycle after release
    a_mode = 1'b0; a_dly = 8; a_d0 = 16'h5555;
    a_eoc = 1'b1; step(1); a_eoc = 1'b0;
    check("a_rst_den", 32'(a_den), 1);
    step(2);
    a_rst = 1'b1;
    step(5);
    check("mid_rst_daddr", 32'(a_daddr), 0);
    check("mid_rst_sdata", 32'(a_sdata), 0);
    check("mid_rst_sch", 32'(a_sch), 0);
    check("mid_rst_all", a_all, 0);
    check("mid_rst_terr", 32'(a_terr), 0);
    check("mid_rst_busy", 32'(a_busy), 1);
    a_rst = 1'b0;
    step(6);
    check("post_rst_busy", 32'(a_busy), 1);
    check("post_rst_all", a_all, 0);
    check("post_rst_sdata", 32'(a_sdata), 0);
    check("post_rst_no_strobe", a_vcnt, 6);

    check("a_sb_empty", a_exp.size(), 0);
    check("b_sb_empty", b_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xadc_drp_scanner.md
Name: xadc_drp_scanner

Overview:
- Parametrised DRP read sequencer for the 7-series XADC; generalises the fixed temperature/VAUX15 dual reader to NUM_CH configurable DRP status addresses.
- Sits between the xadc_wiz_0 DRP port and the monitor blocks (temperature, voltage, future channels).
- Adds per-channel averaging over 2^AVG_LOG2 scans, a choice of EOC-triggered or software-triggered scans, a DRP timeout with sticky error, and a parallel all-channel result bus.

Parameters:
- NUM_CH, 2: number of channels scanned per trigger; range 1..16.
- ADDR_LIST, {7'h1F,7'h00}: packed DRP addresses. Channel i uses bits [7i+6:7i]. Channel 0 is read first in each scan.
- STARTUP_CYCLES, 1_000_000: clk cycles to wait after reset before the first scan (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 255: maximum cycles from den to drdy before a read is declared failed.
- AVG_LOG2, 0: log2 of the number of scans averaged per result; range 0..4. 0 means no averaging.
- Derived localparam CH_W = max(1, $clog2(NUM_CH)).

Ports:
- clk  in  1  DRP/system clock.
- reset  in  1  synchronous, active-high.
- trig_mode  in  1  0 = scan starts on eoc; 1 = scan starts on start.
- start  in  1  software trigger pulse; used only when trig_mode = 1.
- eoc  in  1  XADC end-of-conversion.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  tied 0 (read only).
- drp_di  out  16  tied 0.
- drp_drdy  in  1  DRP data ready.
- drp_do  in  16  DRP read data.
- sample_data  out  16  latest (averaged) result.
- sample_ch  out  CH_W  channel index of sample_data.
- sample_valid  out  1  one-cycle strobe; sample_data and sample_ch are valid.
- all_data  out  16*NUM_CH  per-channel latest result; channel i occupies [16i+15:16i].
- scan_done  out  1  one-cycle strobe after the last channel's averaged result is produced.
- timeout_err  out  1  sticky; set when a DRP read times out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - drp_daddr = 0, drp_den = 0, sample_data = 0, sample_ch = 0, sample_valid = 0.
  - all_data = 0, scan_done = 0, timeout_err = 0, busy = 1.
  - Internal: state = STARTUP, all accumulators and counters = 0.
- Reset asserted mid-read discards the transaction. A drdy arriving after reset is ignored because the FSM is in STARTUP.
- FSM states:
  - STARTUP: counter counts to STARTUP_CYCLES-1, then goes to IDLE.
  - IDLE: busy = 0. Trigger is eoc = 1 (trig_mode = 0) or start = 1 (trig_mode = 1). On trigger: ch_idx <= 0, go to ISSUE.
  - ISSUE: drp_den = 1 for exactly one cycle with drp_daddr = ADDR_LIST[ch_idx]. Timeout counter cleared. Go to WAIT_RDY.
  - WAIT_RDY: the first cycle with drp_drdy = 1 captures drp_do and adds it to acc[ch_idx], then goes to NEXT. If the counter reaches TIMEOUT_CYCLES first: timeout_err <= 1, all accumulators and the scan counter clear, no strobes, go to IDLE (scan aborted).
  - NEXT: if ch_idx = NUM_CH-1, go to ENDSCAN; otherwise ch_idx increments and go to ISSUE.
  - ENDSCAN:
    - scan_cnt increments, wrapping at 2^AVG_LOG2.
    - On wrap, results are emitted over NUM_CH consecutive cycles, channel 0 first. Each cycle: sample_valid = 1, sample_ch = i, sample_data = acc[i] >> AVG_LOG2 (truncated), all_data slice i updated, acc[i] <= 0.
    - scan_done pulses in the cycle after the last emit, then go to IDLE.
    - Without wrap, go directly to IDLE with no strobes.
- Accumulators are 16+AVG_LOG2 bits wide and cannot overflow.
- Latency with AVG_LOG2 = 0 and drdy d cycles after den: the first sample_valid comes NUM_CH*(d+2)+1 cycles after the trigger.
- drp_drdy outside WAIT_RDY is ignored.
- Triggers arriving while busy are dropped, not queued.
- eoc held high re-triggers on the first IDLE cycle after a scan.
- In trig_mode = 1, eoc is ignored.
- trig_mode is sampled only in IDLE.
- timeout_err clears only on reset; scanning continues on later triggers.

Test Plan:
- Startup: with STARTUP_CYCLES = 100, eoc is held high from reset. First drp_den appears at cycle 102 after reset deassertion, with drp_daddr = 7'h00.
- Dual scan (NUM_CH = 2, AVG_LOG2 = 0): on the eoc pulse, the DRP model returns 16'h9C40 for addr 00 and 16'h7FF0 for addr 1F, each 3 cycles after den. Expect sample_valid ch 0 with 9C40, the next cycle ch 1 with 7FF0, then scan_done. all_data = {7FF0, 9C40}.
- Averaging (AVG_LOG2 = 2, NUM_CH = 1): four scans return 100, 101, 102, 105. Expect no strobe for scans 1–3; scan 4 gives sample_data = 102 (408 >> 2).
- Timeout: DRP model never asserts drdy. Expect timeout_err = 1 exactly TIMEOUT_CYCLES after den, no sample_valid, busy = 0. The next scan with a responsive model completes normally and timeout_err stays 1.
- Trigger mode: trig_mode = 1 with eoc toggling gives no den. A start pulse gives one scan. A start pulse during busy is dropped: exactly NUM_CH den pulses in total.
- Reset mid-operation: assert reset in WAIT_RDY and let drdy arrive one cycle after release. Expect all outputs at reset values and no capture.
